// File: rtl/mac_pe_pkg.sv
// Shared types and default parameter values for the output-stationary MAC processing element.
package mac_pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int DEF_IN_WIDTH  = 16;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_K_DEPTH   = 16;
  localparam int DEF_SIGNED    = 1;
  localparam int DEF_SATURATE  = 1;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulator adder: wraps modulo 2^ACC_WIDTH, or clamps to the range limit and flags it.
module mac_sat_add #(
  parameter int ACC_WIDTH = 32,
  parameter int SIGNED    = 1,
  parameter int SATURATE  = 1
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 overflow
);

  logic [ACC_WIDTH:0] raw;
  logic               ovf;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    // Signed overflow: operands agree in sign but the result does not.
    if (SIGNED != 0) ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (raw[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
    else             ovf = raw[ACC_WIDTH];
    sum      = raw[ACC_WIDTH-1:0];
    overflow = 1'b0;
    if ((SATURATE != 0) && ovf) begin
      overflow = 1'b1;
      if (SIGNED != 0) sum = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      else             sum = '1;
    end
  end

endmodule

// File: rtl/mac_pe_os.sv
// Output-stationary MAC PE: forwards operands east/south, accumulates k_len products, holds result for handoff.
module mac_pe_os
  import mac_pe_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int K_DEPTH   = DEF_K_DEPTH,
  parameter int SIGNED    = DEF_SIGNED,
  parameter int SATURATE  = DEF_SATURATE,
  localparam int KW       = $clog2(K_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IN_WIDTH-1:0]  a_i,
  input  logic                 a_valid_i,
  input  logic [IN_WIDTH-1:0]  b_i,
  input  logic                 b_valid_i,
  input  logic [KW-1:0]        k_len_i,
  input  logic                 clr_i,
  output logic [IN_WIDTH-1:0]  a_o,
  output logic                 a_valid_o,
  output logic [IN_WIDTH-1:0]  b_o,
  output logic                 b_valid_o,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 acc_valid_o,
  input  logic                 acc_ready_i,
  output logic                 sat_o,
  output logic                 drop_o
);

  if (ACC_WIDTH < 2 * IN_WIDTH) begin : g_width_check
    $error("mac_pe_os: ACC_WIDTH must be at least 2*IN_WIDTH");
  end

  // Handshake: a pair fires when a_valid_i & b_valid_i; a result is handed off on a cycle
  // where acc_valid_o & acc_ready_i, and acc_o/sat_o stay stable until then.
  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [KW-1:0]        cnt_q;
  logic [KW-1:0]        k_len_q;
  logic                 sat_q;

  logic                 fire;
  logic [KW-1:0]        k_eff;
  logic [KW-1:0]        cnt_nxt;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;

  assign fire    = a_valid_i & b_valid_i;
  assign k_eff   = (k_len_i == '0) ? KW'(1) : k_len_i;
  assign cnt_nxt = cnt_q + KW'(1);

  if (SIGNED != 0) begin : g_prod_s
    logic signed [2*IN_WIDTH-1:0] prod;
    assign prod     = $signed(a_i) * $signed(b_i);
    assign prod_ext = ACC_WIDTH'(prod);
  end else begin : g_prod_u
    logic [2*IN_WIDTH-1:0] prod;
    assign prod     = a_i * b_i;
    assign prod_ext = ACC_WIDTH'(prod);
  end

  mac_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED),
    .SATURATE  (SATURATE)
  ) u_add (
    .a        (acc_q),
    .b        (prod_ext),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      k_len_q   <= '0;
      sat_q     <= 1'b0;
      a_o       <= '0;
      a_valid_o <= 1'b0;
      b_o       <= '0;
      b_valid_o <= 1'b0;
    end else begin
      a_o       <= a_i;
      a_valid_o <= a_valid_i;
      b_o       <= b_i;
      b_valid_o <= b_valid_i;
      if (clr_i) begin
        state_q <= ST_IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
        sat_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (fire) begin
            k_len_q <= k_eff;
            acc_q   <= prod_ext;
            cnt_q   <= KW'(1);
            sat_q   <= 1'b0;
            state_q <= (k_eff == KW'(1)) ? ST_HOLD : ST_ACC;
          end
          ST_ACC: if (fire) begin
            acc_q   <= add_sum;
            cnt_q   <= cnt_nxt;
            sat_q   <= sat_q | add_ovf;
            if (cnt_nxt == k_len_q) state_q <= ST_HOLD;
          end
          ST_HOLD: if (acc_ready_i) begin
            // A pair arriving with the handoff starts the next result immediately.
            if (fire) begin
              k_len_q <= k_eff;
              acc_q   <= prod_ext;
              cnt_q   <= KW'(1);
              sat_q   <= 1'b0;
              state_q <= (k_eff == KW'(1)) ? ST_HOLD : ST_ACC;
            end else begin
              acc_q   <= '0;
              cnt_q   <= '0;
              sat_q   <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign acc_o       = acc_q;
  assign sat_o       = sat_q;
  assign acc_valid_o = (state_q == ST_HOLD);
  assign drop_o      = (state_q == ST_HOLD) & fire & ~acc_ready_i & ~clr_i & ~rst_i;

endmodule

// File: tb/tb_mac_pe_os.sv
// Directed bench for mac_pe_os: saturating (default) and wrapping instances share one stimulus stream.
module tb_mac_pe_os;
  import mac_pe_pkg::*;

  localparam int IW = 16;
  localparam int AW = 32;
  localparam int KW = 5;

  logic          clk = 1'b0;
  logic          rst_i, a_valid_i, b_valid_i, clr_i, acc_ready_i;
  logic [IW-1:0] a_i, b_i;
  logic [KW-1:0] k_len_i;

  logic [IW-1:0] a_o, b_o, wa_o, wb_o;
  logic          a_valid_o, b_valid_o, wa_valid_o, wb_valid_o;
  logic [AW-1:0] acc_o, wacc_o;
  logic          acc_valid_o, sat_o, drop_o, wacc_valid_o, wsat_o, wdrop_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_pe_os dut (
    .clk_i(clk), .rst_i(rst_i), .a_i(a_i), .a_valid_i(a_valid_i), .b_i(b_i), .b_valid_i(b_valid_i),
    .k_len_i(k_len_i), .clr_i(clr_i), .a_o(a_o), .a_valid_o(a_valid_o), .b_o(b_o), .b_valid_o(b_valid_o),
    .acc_o(acc_o), .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i), .sat_o(sat_o), .drop_o(drop_o)
  );

  mac_pe_os #(.SATURATE(0)) dut_wrap (
    .clk_i(clk), .rst_i(rst_i), .a_i(a_i), .a_valid_i(a_valid_i), .b_i(b_i), .b_valid_i(b_valid_i),
    .k_len_i(k_len_i), .clr_i(clr_i), .a_o(wa_o), .a_valid_o(wa_valid_o), .b_o(wb_o), .b_valid_o(wb_valid_o),
    .acc_o(wacc_o), .acc_valid_o(wacc_valid_o), .acc_ready_i(acc_ready_i), .sat_o(wsat_o), .drop_o(wdrop_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pair(input logic [IW-1:0] a, input logic [IW-1:0] b);
    a_i = a; b_i = b; a_valid_i = 1'b1; b_valid_i = 1'b1;
  endtask

  task automatic no_pair();
    a_valid_i = 1'b0; b_valid_i = 1'b0;
  endtask

  task automatic handoff();
    acc_ready_i = 1'b1; tick(); acc_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; a_i = '0; b_i = '0; a_valid_i = 1'b0; b_valid_i = 1'b0;
    k_len_i = '0; clr_i = 1'b0; acc_ready_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;

    // Reset state
    chk("rst_acc", acc_o, 32'h0);
    chk("rst_valid", {31'b0, acc_valid_o}, 32'h0);
    chk("rst_sat", {31'b0, sat_o}, 32'h0);
    chk("rst_drop", {31'b0, drop_o}, 32'h0);
    chk("rst_fwd", {a_o, b_o}, 32'h0);
    chk("rst_fwd_v", {30'b0, a_valid_o, b_valid_o}, 32'h0);

    // Four-pair dot product, result held while ready is low
    k_len_i = 5'd4;
    pair(16'd1, 16'd2); tick();
    pair(16'd3, 16'd4); tick();
    pair(16'd5, 16'd6); tick();
    chk("dot_not_yet", {31'b0, acc_valid_o}, 32'h0);
    pair(16'd7, 16'd8); tick();
    no_pair();
    chk("dot_valid", {31'b0, acc_valid_o}, 32'h1);
    chk("dot_acc", acc_o, 32'd100);
    tick(); tick();
    chk("dot_hold_valid", {31'b0, acc_valid_o}, 32'h1);
    chk("dot_hold_acc", acc_o, 32'd100);
    handoff();
    chk("dot_after_valid", {31'b0, acc_valid_o}, 32'h0);
    chk("dot_after_acc", acc_o, 32'h0);

    // Signed single product: -3 * 5
    k_len_i = 5'd1;
    pair(16'hFFFD, 16'd5); tick(); no_pair();
    chk("neg_acc", acc_o, 32'hFFFF_FFF1);
    chk("neg_sat", {31'b0, sat_o}, 32'h0);
    chk("neg_valid", {31'b0, acc_valid_o}, 32'h1);
    handoff();

    // Positive overflow: clamp vs wrap
    k_len_i = 5'd3;
    repeat (3) begin pair(16'h7FFF, 16'h7FFF); tick(); end
    no_pair();
    chk("posov_sat_acc", acc_o, 32'h7FFF_FFFF);
    chk("posov_sat_flag", {31'b0, sat_o}, 32'h1);
    chk("posov_wrap_acc", wacc_o, 32'hBFFD_0003);
    chk("posov_wrap_flag", {31'b0, wsat_o}, 32'h0);
    handoff();
    chk("posov_sat_cleared", {31'b0, sat_o}, 32'h0);

    // Negative overflow: -32768 * 32767 three times
    repeat (3) begin pair(16'h8000, 16'h7FFF); tick(); end
    no_pair();
    chk("negov_sat_acc", acc_o, 32'h8000_0000);
    chk("negov_sat_flag", {31'b0, sat_o}, 32'h1);
    chk("negov_wrap_acc", wacc_o, 32'h4001_8000);
    handoff();

    // k_len of zero behaves as one
    k_len_i = 5'd0;
    pair(16'd3, 16'd3); tick(); no_pair();
    chk("k0_valid", {31'b0, acc_valid_o}, 32'h1);
    chk("k0_acc", acc_o, 32'd9);
    handoff();

    // Drop while holding, then handoff with a pair that starts the next result
    k_len_i = 5'd1;
    pair(16'd4, 16'd5); tick();
    pair(16'd9, 16'd9); #1;
    chk("drop_pulse", {31'b0, drop_o}, 32'h1);
    tick(); no_pair(); #1;
    chk("drop_gone", {31'b0, drop_o}, 32'h0);
    chk("drop_acc_kept", acc_o, 32'd20);
    chk("drop_valid_kept", {31'b0, acc_valid_o}, 32'h1);
    acc_ready_i = 1'b1; k_len_i = 5'd2; pair(16'd2, 16'd3); #1;
    chk("handoff_no_drop", {31'b0, drop_o}, 32'h0);
    tick(); acc_ready_i = 1'b0;
    chk("chain_first_acc", acc_o, 32'd6);
    chk("chain_first_valid", {31'b0, acc_valid_o}, 32'h0);
    pair(16'd1, 16'd1); tick(); no_pair();
    chk("chain_result", acc_o, 32'd7);
    chk("chain_valid", {31'b0, acc_valid_o}, 32'h1);
    handoff();

    // Lone valid forwards but does not accumulate
    a_i = 16'h1234; a_valid_i = 1'b1; b_valid_i = 1'b0; tick();
    chk("lone_a_o", {16'b0, a_o}, 32'h1234);
    chk("lone_a_v", {30'b0, a_valid_o, b_valid_o}, 32'h2);
    chk("lone_state", 32'(dut.state_q), 32'(ST_IDLE));
    a_valid_i = 1'b0; b_i = 16'hBEEF; b_valid_i = 1'b1; tick();
    chk("lone_b_o", {16'b0, b_o}, 32'hBEEF);
    chk("lone_b_v", {30'b0, a_valid_o, b_valid_o}, 32'h1);
    chk("lone_b_acc", acc_o, 32'h0);
    no_pair();

    // Reset mid-accumulation, then a fresh sequence
    k_len_i = 5'd4;
    pair(16'd10, 16'd10); tick();
    pair(16'd10, 16'd10); tick();
    rst_i = 1'b1; pair(16'd5, 16'd5); tick(); rst_i = 1'b0; no_pair();
    chk("midrst_acc", acc_o, 32'h0);
    chk("midrst_valid", {31'b0, acc_valid_o}, 32'h0);
    chk("midrst_fwd", {a_o, b_o}, 32'h0);
    chk("midrst_fwd_v", {30'b0, a_valid_o, b_valid_o}, 32'h0);
    for (int i = 1; i <= 4; i++) begin pair(IW'(i), IW'(i)); tick(); end
    no_pair();
    chk("midrst_fresh", acc_o, 32'd30);
    handoff();

    // Clear mid-accumulation: forwarding unaffected, no stale contribution
    pair(16'd10, 16'd10); tick();
    pair(16'd10, 16'd10); tick();
    clr_i = 1'b1; pair(16'd5, 16'd6); tick(); clr_i = 1'b0; no_pair();
    chk("clr_acc", acc_o, 32'h0);
    chk("clr_valid", {31'b0, acc_valid_o}, 32'h0);
    chk("clr_fwd", {a_o, b_o}, {16'd5, 16'd6});
    for (int i = 1; i <= 4; i++) begin pair(16'd2, IW'(i)); tick(); end
    no_pair();
    chk("clr_fresh", acc_o, 32'd20);

    // Clear while holding discards the pending result
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("clr_hold_valid", {31'b0, acc_valid_o}, 32'h0);
    chk("clr_hold_acc", acc_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
